// File: rtl/effects_pkg.sv
// rtl/effects_pkg.sv - shared level constants, ramp state type and target clamp
package effects_pkg;

    localparam int MAX_LEVEL = 8;
    localparam int LEVEL_W   = 4;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } ramp_state_t;

    // Intensity codes above full effect saturate to full effect.
    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] raw);
        return (raw > LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : raw;
    endfunction

endpackage

// File: rtl/level_slew.sv
// rtl/level_slew.sv - accept-paced step counter and one-step-per-event level slewer
import effects_pkg::*;

module level_slew #(
    parameter int RAMP_DIV = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               accept,
    input  logic [LEVEL_W-1:0] target,
    output logic [LEVEL_W-1:0] level
);

    localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    ramp_state_t        ramp_state;
    logic               step;

    // Ramp direction is re-derived every cycle, so a new target redirects the
    // ramp at the very next step event without touching the counter.
    always_comb begin
        ramp_state = HOLD;
        cnt_d      = cnt_q;
        level_d    = level_q;
        step       = accept && (cnt_q == CNT_LAST);

        if (level_q < target) begin
            ramp_state = RISING;
        end else if (level_q > target) begin
            ramp_state = FALLING;
        end

        if (accept) begin
            cnt_d = step ? '0 : cnt_q + 1'b1;
        end

        if (step) begin
            unique case (ramp_state)
                RISING:  level_d = level_q + 1'b1;
                FALLING: level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Counter and level registers; both hold whenever nothing is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/volume_ramp.sv
// rtl/volume_ramp.sv - one-deep skid-free sample stage scaling audio by (8-level)/8
import effects_pkg::*;

module volume_ramp #(
    parameter int DATA_W   = 12,
    parameter int RAMP_DIV = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LEVEL_W-1:0]       intensity,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LEVEL_W-1:0]       level
);

    localparam int PROD_W = DATA_W + 4;

    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     accept;
    logic [LEVEL_W-1:0]       target;
    logic [LEVEL_W-1:0]       gain;
    logic signed [PROD_W-1:0] in_ext, gain_ext, prod;

    assign target   = clamp_level(intensity);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    level_slew #(
        .RAMP_DIV (RAMP_DIV)
    ) u_level_slew (
        .clk    (clk),
        .reset  (reset),
        .accept (accept),
        .target (target),
        .level  (level)
    );

    // Scale by (8-level) in a 4-bit-wider signed product; the arithmetic
    // shift floors, and |result| <= |in_data| so it always fits DATA_W.
    always_comb begin
        gain        = LEVEL_W'(MAX_LEVEL) - level;
        in_ext      = {{4{in_data[DATA_W-1]}}, in_data};
        gain_ext    = $signed({{DATA_W{1'b0}}, gain});
        prod        = in_ext * gain_ext;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = DATA_W'(prod >>> 3);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset drops any pending sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_volume_ramp.sv
// tb/tb_volume_ramp.sv - randomized and directed bench against a sample-level reference model
module tb_volume_ramp;

    localparam int DW   = 12;
    localparam int RDIV = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           intensity;
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           level;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: applied level, accepts since last step, pending output
    int m_level;
    int m_cnt;
    int m_valid;
    int m_data;

    volume_ramp #(
        .DATA_W   (DW),
        .RAMP_DIV (RDIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .intensity (intensity),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // floor(x * (8 - lvl) / 8) by plain integer division
    function automatic int scale(input int x, input int lvl);
        int p;
        p = x * (8 - lvl);
        if (p >= 0) return p / 8;
        return -((-p + 7) / 8);
    endfunction

    task automatic model_reset();
        m_level = 0;
        m_cnt   = 0;
        m_valid = 0;
        m_data  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'($signed(out_data)), 0);
        check("rst_level", int'(level), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_cycle(input int iv, input int din, input int inten, input int ordy);
        int tgt;
        int rdy;
        bit acc;
        @(negedge clk);
        in_valid  = (iv != 0);
        in_data   = DW'(din);
        intensity = 4'(inten);
        out_ready = (ordy != 0);
        #1;
        rdy = (m_valid == 0 || ordy != 0) ? 1 : 0;
        check("in_ready", int'(in_ready), rdy);
        acc = (iv != 0) && (rdy != 0);
        @(posedge clk);
        #1;
        tgt = (inten > 8) ? 8 : inten;
        if (acc) begin
            m_data  = scale(din, m_level);
            m_valid = 1;
            if (m_cnt == RDIV - 1) begin
                if (m_level < tgt) m_level++;
                else if (m_level > tgt) m_level--;
            end
            m_cnt = (m_cnt + 1) % RDIV;
        end else if (ordy != 0) begin
            m_valid = 0;
        end
        check("out_valid", int'(out_valid), m_valid);
        check("out_data", int'($signed(out_data)), m_data);
        check("level", int'(level), m_level);
    endtask

    initial begin
        reset     = 1'b0;
        intensity = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // no effect: samples pass unchanged
        do_reset();
        repeat (12) do_cycle(1, 1000, 0, 1);
        check("pass_data", int'($signed(out_data)), 1000);
        check("pass_level", int'(level), 0);

        // full ramp: 800 steps down by 100 every RDIV samples
        do_reset();
        do_cycle(1, 800, 8, 1);
        check("ramp_first", int'($signed(out_data)), 800);
        repeat (32) do_cycle(1, 800, 8, 1);
        check("ramp_level8", int'(level), 8);
        check("ramp_last", int'($signed(out_data)), 0);

        // rounding toward negative infinity and extreme negative input
        do_reset();
        do_cycle(1, -2048, 0, 1);
        check("neg_full", int'($signed(out_data)), -2048);
        do_reset();
        repeat (16) do_cycle(1, 100, 4, 1);
        do_cycle(1, -5, 4, 1);
        check("neg_floor", int'($signed(out_data)), -3);
        check("neg_level", int'(level), 4);

        // downstream stall holds everything
        repeat (5) begin
            do_cycle(1, 50, 8, 0);
            check("stall_data", int'($signed(out_data)), -3);
            check("stall_level", int'(level), 4);
        end
        do_cycle(0, 0, 4, 1);

        // redirect mid-count: up to 5, then down to 2
        do_reset();
        repeat (20) do_cycle(1, 400, 5, 1);
        check("redir_up", int'(level), 5);
        repeat (2) do_cycle(1, 400, 5, 1);
        repeat (12) do_cycle(1, 400, 2, 1);
        check("redir_down", int'(level), 2);
        repeat (8) do_cycle(1, 400, 2, 1);
        check("redir_hold", int'(level), 2);

        // reset while stalled at level 6, then ramp to clamp
        do_reset();
        repeat (24) do_cycle(1, 300, 15, 1);
        do_cycle(1, 300, 15, 0);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_level", int'(level), 6);
        do_reset();
        repeat (3) do_cycle(0, 0, 15, 1);
        repeat (40) do_cycle(1, 300, 15, 1);
        check("clamp_level", int'(level), 8);

        // randomized traffic against the model
        do_reset();
        begin
            int inten;
            inten = 0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 31) == 0) inten = int'($urandom_range(0, 15));
                if ($urandom_range(0, 199) == 0) do_reset();
                do_cycle(($urandom_range(0, 3) != 0) ? 1 : 0,
                         int'($urandom_range(0, 4095)) - 2048,
                         inten,
                         ($urandom_range(0, 3) != 0) ? 1 : 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
